prio_encoder_rr: RTL and testbench
==================================

PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 Parameter N, default 8, SHALL set the number of request inputs; legal range 2..64, and a power of two is not required.
REQ-002 Localparam W, fixed at $clog2(N), SHALL set the index width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  input  1  SHALL enable request sampling when high.
REQ-006 mode  input  1  SHALL select the arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-007 req  input  N  SHALL carry the request vector, one bit per channel.
REQ-008 out_ready  input  1  SHALL be the consumer accept signal.
REQ-009 out_valid  output  1  SHALL indicate that a registered result is presented.
REQ-010 out_idx  output  W  SHALL carry the encoded index of the winning channel.
REQ-011 out_grant  output  N  SHALL carry the one-hot grant of the winning channel.
REQ-012 none  output  1  SHALL indicate that the last enabled sample had no request, replacing an undefined index.

Function
REQ-013 The block SHALL implement states IDLE (no result held) and HOLD (result presented, out_valid=1).
REQ-014 Fixed priority (mode=0) SHALL select the highest set index of req.
REQ-015 Round-robin (mode=1) SHALL search req upward from pointer ptr, wrapping from N-1 to 0, and SHALL select the first set bit.
REQ-016 In IDLE with en=1 and req!=0 at an edge, the block SHALL register out_idx, out_grant and out_valid=1, clear none, and enter HOLD; latency SHALL be 1 cycle from the sampling edge.
REQ-017 In IDLE with en=1 and req==0, the block SHALL set none=1, keep out_valid=0, leave out_idx and out_grant unchanged, and stay in IDLE.
REQ-018 In IDLE with en=0, all outputs and ptr SHALL hold their values.
REQ-019 In HOLD with out_ready=0, out_idx, out_grant and out_valid SHALL remain stable regardless of changes on req, mode or en.
REQ-020 In HOLD with out_ready=1, the held result SHALL be accepted at that edge.
REQ-021 On acceptance with en=1 and req!=0 at the same edge, a new result SHALL be loaded and the block SHALL stay in HOLD, giving back-to-back throughput of 1 result per cycle.
REQ-022 On acceptance otherwise, the block SHALL clear out_valid and out_grant, return to IDLE, and set none = (en && req==0).
REQ-023 ptr SHALL be W bits and SHALL update only on acceptance of a result produced in mode=1, to out_idx+1, wrapping to 0 when out_idx=N-1.
REQ-024 Results produced in mode=0 SHALL leave ptr unchanged.
REQ-025 The mode value SHALL be sampled only at the load edge; a mode change while in HOLD SHALL not alter the held result.
REQ-026 The round-robin search SHALL use the ptr value after the same-edge update, i.e. the post-acceptance pointer.
REQ-027 out_grant SHALL always equal the one-hot decode of out_idx when out_valid=1, and SHALL be 0 otherwise.
REQ-028 No output SHALL ever be X or Z after reset, including for req==0.

Reset
REQ-029 Assertion of rst_n=0 SHALL immediately, without waiting for a clock, force out_valid=0, out_idx=0, out_grant=0, none=0, ptr=0 and state IDLE, including while in HOLD.
REQ-030 Release of rst_n SHALL take effect synchronously; the first sample SHALL occur at the first rising edge of clk with rst_n=1.

Verification
REQ-031 With N=8, mode=0, en=1, out_ready=1, req=8'b0101_0010, the next edge SHALL give out_valid=1, out_idx=6 and out_grant=8'b0100_0000.
REQ-032 With mode=0, en=1, req=8'h00, the bench SHALL see none=1 and out_valid=0, with no X on any output.
REQ-033 With mode=1, req=8'hFF held, out_ready=1, the bench SHALL see out_idx run 0,1,2,...,7,0 on consecutive cycles.
REQ-034 With mode=1, req=8'b1000_0001, out_ready=1, the bench SHALL see out_idx alternate 0,7,0,7.
REQ-035 With a result held and out_ready=0 for 3 cycles while req toggles, out_idx and out_valid SHALL stay constant; on out_ready=1 they SHALL advance by exactly one result.
REQ-036 With rst_n pulsed low mid-cycle while in HOLD, all outputs SHALL be 0 before the next clock edge, and the next round-robin grant SHALL start from ptr=0.

Source files
------------

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered priority encoder with a one-entry output stage.
// mode=0 grants the highest requesting channel. mode=1 grants round-robin,
// searching upward from a pointer that advances past each accepted RR winner.
// The result is held stable until the consumer accepts it with out_ready.
// A new result can load on the same edge that accepts the previous one.
module prio_encoder_rr #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_grant,
  output logic         none
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);
  localparam logic [W:0]   N_EXT    = (W + 1)'(N);

  state_t       state, state_nxt;
  logic [W-1:0] ptr, ptr_nxt;
  logic         res_mode, res_mode_nxt;   // mode the held result was produced in
  logic         valid_nxt, none_nxt;
  logic [W-1:0] idx_nxt;
  logic [N-1:0] grant_nxt;

  logic         accept;
  logic         any_req;
  logic         load;
  logic [W-1:0] fp_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] win_idx;

  assign any_req = |req;
  assign accept  = (state == HOLD) && out_ready;
  assign load    = en && any_req && ((state == IDLE) || accept);

  // Pointer as it stands after this edge; the RR search must use it so that
  // back-to-back RR grants rotate correctly.
  always_comb begin
    ptr_nxt = ptr;
    if (accept && res_mode) begin
      ptr_nxt = (out_idx == LAST_IDX) ? '0 : out_idx + 1'b1;
    end
  end

  // Fixed priority: highest set bit wins, so later loop iterations override.
  always_comb begin
    // NOTE: every always_comb output gets a default first; without it a path
    // that skips the assignment would infer a latch.
    fp_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fp_idx = W'(i);
    end
  end

  // Round-robin: rotate req so ptr_nxt lands at bit 0, take the lowest set bit
  // and map its position back to a channel number modulo N.
  always_comb begin
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   pos;
    logic [W:0]     sum;
    dbl = {req, req};
    rot = N'(dbl >> ptr_nxt);
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = W'(i);
    end
    sum    = {1'b0, ptr_nxt} + {1'b0, pos};
    rr_idx = (sum >= N_EXT) ? W'(sum - N_EXT) : W'(sum);
  end

  assign win_idx = mode ? rr_idx : fp_idx;

  // Next-state and next-output selection for the IDLE/HOLD controller.
  always_comb begin
    state_nxt    = state;
    valid_nxt    = out_valid;
    idx_nxt      = out_idx;
    grant_nxt    = out_grant;
    none_nxt     = none;
    res_mode_nxt = res_mode;

    if (load) begin
      state_nxt    = HOLD;
      valid_nxt    = 1'b1;
      idx_nxt      = win_idx;
      grant_nxt    = N'(1) << win_idx;
      none_nxt     = 1'b0;
      res_mode_nxt = mode;
    end else begin
      case (state)
        IDLE: begin
          // Enabled sample with nothing requested: flag it, keep index as is.
          if (en) none_nxt = 1'b1;
        end
        HOLD: begin
          if (accept) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            grant_nxt = '0;
            none_nxt  = en && !any_req;
          end
        end
        default: begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          grant_nxt = '0;
        end
      endcase
    end
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_grant <= '0;
      none      <= 1'b0;
      ptr       <= '0;
      res_mode  <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= valid_nxt;
      out_idx   <= idx_nxt;
      out_grant <= grant_nxt;
      none      <= none_nxt;
      ptr       <= ptr_nxt;
      res_mode  <= res_mode_nxt;
    end
  end

  // Grant is always the one-hot decode of the index while valid, else zero.
  a_grant_decode: assert property (@(posedge clk) disable iff (!rst_n)
    out_grant == (out_valid ? (N'(1) << out_idx) : '0));

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Self-checking bench for prio_encoder_rr: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the arbiter.
module tb_prio_encoder_rr;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic [N-1:0] req = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_grant;
  logic         none;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  bit m_valid;
  int m_idx;
  bit m_none;
  int m_ptr;
  bit m_mode;

  prio_encoder_rr #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_grant (out_grant),
    .none      (none)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int fixed_pick(input logic [N-1:0] r);
    int w = -1;
    for (int i = 0; i < N; i++) if (r[i]) w = i;
    return w;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_idx = 0; m_none = 0; m_ptr = 0; m_mode = 0;
  endtask

  // Apply one rising edge to the model using the inputs present at that edge.
  task automatic model_edge();
    bit acc;
    int p;
    acc = m_valid && out_ready;
    p = m_ptr;
    if (acc && m_mode) p = (m_idx + 1) % N;
    if (en && req != 0 && (!m_valid || acc)) begin
      m_valid = 1;
      m_idx   = mode ? rr_pick(req, p) : fixed_pick(req);
      m_none  = 0;
      m_mode  = mode;
    end else if (!m_valid) begin
      if (en && req == 0) m_none = 1;
    end else if (acc) begin
      m_valid = 0;
      m_none  = en && req == 0;
    end
    m_ptr = p;
  endtask

  task automatic compare_model(input string tag);
    logic [N-1:0] g;
    g = m_valid ? (N'(1) << m_idx) : '0;
    check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".idx"},   64'(out_idx),   64'(m_idx));
    check({tag, ".grant"}, 64'(out_grant), 64'(g));
    check({tag, ".none"},  64'(none),      64'(m_none));
    check({tag, ".noX"},   64'($isunknown({out_valid, out_idx, out_grant, none})), 64'(0));
  endtask

  // One clock edge: advance model, sample DUT 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_model(tag);
  endtask

  task automatic drive(input bit e, input bit m, input logic [N-1:0] r, input bit rdy);
    en = e; mode = m; req = r; out_ready = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #13;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();
    #1;
    check("reset.valid", 64'(out_valid), 64'(0));
    check("reset.idx",   64'(out_idx),   64'(0));
    check("reset.grant", 64'(out_grant), 64'(0));
    check("reset.none",  64'(none),      64'(0));

    // Fixed priority picks highest set bit.
    drive(1, 0, 8'b0101_0010, 1);
    step("fp");
    check("fp.idx6",   64'(out_idx),   64'(6));
    check("fp.grant",  64'(out_grant), 64'(8'b0100_0000));
    check("fp.valid1", 64'(out_valid), 64'(1));

    // No request: none flag, no valid, no X.
    drive(1, 0, 8'h00, 1);
    step("none");
    check("none.flag",  64'(none),      64'(1));
    check("none.valid", 64'(out_valid), 64'(0));
    drive(1, 0, 8'h00, 1);
    step("none2");

    // Round-robin over all channels: 0..7 then 0.
    for (int i = 0; i <= N; i++) begin
      drive(1, 1, 8'hFF, 1);
      step("rrff");
      check("rrff.seq", 64'(out_idx), 64'(i % N));
    end
    drive(0, 0, 8'h00, 1);
    step("drain");
    do_reset();
    #1;

    // Two requesters alternate.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 8'b1000_0001, 1);
      step("rr81");
      check("rr81.seq", 64'(out_idx), 64'((i % 2) ? 7 : 0));
    end

    // Hold stability with out_ready low while req, mode, en wiggle.
    drive(0, 0, 8'h00, 1);
    step("drain2");
    drive(1, 0, 8'h10, 0);
    step("hold.load");
    for (int i = 0; i < 3; i++) begin
      drive(i[0], ~i[0], (i % 2) ? 8'hFF : 8'h03, 0);
      step("hold");
      check("hold.idx",   64'(out_idx),   64'(4));
      check("hold.valid", 64'(out_valid), 64'(1));
    end
    drive(1, 0, 8'h03, 1);
    step("hold.adv");
    check("hold.adv.idx", 64'(out_idx), 64'(1));
    drive(1, 0, 8'h00, 1);
    step("hold.drain");

    // Async reset in HOLD with a non-zero pointer, then RR restarts from 0.
    drive(1, 1, 8'hFF, 1);
    step("pre1");
    drive(1, 1, 8'hFF, 1);
    step("pre2");
    drive(1, 1, 8'hFF, 0);
    step("pre3");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst.valid", 64'(out_valid), 64'(0));
    check("arst.idx",   64'(out_idx),   64'(0));
    check("arst.grant", 64'(out_grant), 64'(0));
    check("arst.none",  64'(none),      64'(0));
    #2;
    rst_n = 1'b1;
    drive(1, 1, 8'b1000_0100, 1);
    step("arst.rr");
    check("arst.rr.idx", 64'(out_idx), 64'(2));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & N'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      drive($urandom_range(0, 3) != 0, 1'($urandom), r, $urandom_range(0, 2) != 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
